output_serializer: RTL and testbench

OUTPUT_SERIALIZER -- requirements
Module: output_serializer

---
 rtl/output_serializer.sv | 258 +++++++++++++++++++++++++
 tb/tb_output_serializer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_serializer.sv
// output_serializer: buffers 16-bit words from the CPU output register in a
// small FIFO and shifts each one out on a UART-style serial line as two
// framed bytes (low byte first, start bit, 8 data bits LSB first, stop bit).
// Optional feature macro: OUTPUT_SERIALIZER_PARITY_EN adds an even-parity bit
// between data bit 7 and the stop bit of every byte.
`timescale 1ns/1ps

module output_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TMR_W  = $clog2(CLKS_PER_BIT);

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    // FSM state
    state_t r_state;
    state_t w_state_next;

    // Bit timing and word shifting
    logic [TMR_W-1:0]  r_timer;
    logic [2:0]        r_bit_idx;
    logic              r_byte_sel;
    logic [DATA_W-1:0] r_shift;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
    logic              r_parity;
`endif

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;

    // Registered outputs
    logic r_tx;
    logic r_busy;
    logic r_data_ready;
    logic r_overflow;

    // Combinational helpers
    logic w_bit_done;
    logic w_fifo_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_tx_next;

    assign w_bit_done   = (r_timer == TMR_W'(CLKS_PER_BIT - 1));
    assign w_fifo_empty = (r_count == '0);
    // data_ready is a register, so a pop on this edge cannot make room early
    assign w_push       = data_valid & r_data_ready;
    assign w_drop       = data_valid & ~r_data_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; also decides when the head word is popped
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = ST_START;
                    w_pop        = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef OUTPUT_SERIALIZER_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef OUTPUT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    if (!r_byte_sel) begin
                        // High byte follows the low byte with no idle gap
                        w_state_next = ST_START;
                    end else if (!w_fifo_empty) begin
                        // Next word starts straight after this stop bit
                        w_state_next = ST_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: serial line level for the current state
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            ST_IDLE:   w_tx_next = 1'b1;
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_shift[0];
`ifdef OUTPUT_SERIALIZER_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            ST_STOP:   w_tx_next = 1'b1;
            default:   w_tx_next = 1'b1;
        endcase
    end

    // Output registers: tx trails the state by one edge, busy tracks the state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    // FIFO occupancy after this edge's push and pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO pointers, count, ready and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_ready <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count      <= w_count_next;
            r_data_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; words offered during reset are not captured
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Bit timer, bit index, byte select and shift register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_byte_sel <= 1'b0;
            r_shift    <= '0;
        end else begin
            if ((r_state == ST_IDLE) || w_bit_done) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_pop) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_byte_sel <= 1'b0;
            end else if ((r_state == ST_STOP) && w_bit_done && !r_byte_sel) begin
                r_byte_sel <= 1'b1;
            end

            // After eight shifts of the low byte the high byte sits in [7:0]
            if ((r_state == ST_DATA) && w_bit_done) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    // Even parity of the byte about to be shifted, captured during its start bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (r_state == ST_START) begin
            r_parity <= ^r_shift[7:0];
        end
    end
`endif

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign data_ready = r_data_ready;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_output_serializer.sv
// tb_output_serializer: scoreboard bench for output_serializer with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4. Expected serial bits are queued when a
// word is driven and a line monitor pops and compares them as tx produces them.
`timescale 1ns/1ps

module tb_output_serializer;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned WORD_BITS = 2 * FRAME_BITS;
    localparam int unsigned WORD_CYC  = WORD_BITS * CPB;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      data_in;
    logic             data_valid;
    logic             data_ready;
    logic             tx;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    output_serializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    logic        exp_q[$];
    int unsigned start_q[$];

    bit   mon_active = 1'b0;
    logic mon_bit;
    int   mon_samp;
    int   mon_bits;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line bits for one word: two framed bytes, low byte first
    function automatic void push_word_bits(input logic [15:0] w);
        logic [7:0] by;
        for (int b = 0; b < 2; b++) begin
            by = (b == 0) ? w[7:0] : w[15:8];
            exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_q.push_back(by[i]);
`ifdef OUTPUT_SERIALIZER_PARITY_EN
            exp_q.push_back(^by);
`endif
            exp_q.push_back(1'b1);
        end
    endfunction

    // Line monitor: every sample of every bit must match the scoreboard head
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: tx=%b at cycle %0d, required idle 1", tx, cyc);
                end else begin
                    mon_active = 1'b1;
                    mon_samp   = 0;
                    mon_bits   = 0;
                    mon_bit    = exp_q.pop_front();
                    start_q.push_back(cyc);
                end
            end
            if (mon_active) begin
                tests++;
                if (tx !== mon_bit) begin
                    fails++;
                    $display("FAIL tx_bit: bit %0d sample %0d cycle %0d tx=%b required %b",
                             mon_bits, mon_samp, cyc, tx, mon_bit);
                end
                mon_samp++;
                if (mon_samp == CPB) begin
                    mon_samp = 0;
                    mon_bits++;
                    if (mon_bits == WORD_BITS) begin
                        mon_active = 1'b0;
                    end else if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard_underflow: no expected bit at cycle %0d", cyc);
                        mon_active = 1'b0;
                    end else begin
                        mon_bit = exp_q.pop_front();
                    end
                end
            end
        end
    end

    // Waits until every queued bit has been seen on the line, up to a budget
    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        data_valid = 1'b1;
        data_in    = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b required 1", tx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", data_ready); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        data_valid = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_ignore_valid: count %0d required 0", fifo_count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_single_word();
        bit ok;
        start_q.delete();
        @(negedge clk);
        push_word_bits(16'hA55A);
        data_in    = 16'hA55A;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        for (int n = 0; n <= int'(WORD_CYC) + 2; n++) begin
            @(negedge clk);
            if (n == 0) begin
                tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_tx_e0: got %b required 1", tx); end
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_e0: got %b required 0", busy); end
            end
            if (n == 1) begin
                tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_tx_e1: got %b required 1", tx); end
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_e1: got %b required 1", busy); end
            end
            if (n == 2) begin
                tests++; if (tx !== 1'b0) begin fails++; $display("FAIL single_start_latency: got %b required 0", tx); end
            end
            if (n == int'(WORD_CYC)) begin
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_last: got %b required 1", busy); end
            end
            if (n == int'(WORD_CYC) + 1) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_done: got %b required 0", busy); end
            end
            if (n == int'(WORD_CYC) + 2) begin
                tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_idle_tx: got %b required 1", tx); end
            end
        end
        wait_drain(10, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_drain: %0d bits left, required 0", exp_q.size()); end
        tests++; if (start_q.size() != 1) begin fails++; $display("FAIL single_frames: got %0d required 1", start_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int unsigned t0;
        int unsigned t1;
        start_q.delete();
        @(negedge clk);
        push_word_bits(16'h0001);
        push_word_bits(16'h0002);
        data_in    = 16'h0001;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in = 16'h0002;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        wait_drain(3 * int'(WORD_CYC), ok);
        tests++; if (!ok) begin fails++; $display("FAIL b2b_drain: %0d bits left, required 0", exp_q.size()); end
        tests++;
        if (start_q.size() != 2) begin
            fails++;
            $display("FAIL b2b_frames: got %0d required 2", start_q.size());
        end else begin
            t0 = start_q.pop_front();
            t1 = start_q.pop_front();
            if (t1 - t0 != WORD_CYC) begin
                fails++;
                $display("FAIL b2b_gap: word spacing %0d cycles required %0d", t1 - t0, WORD_CYC);
            end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_overflow();
        bit          ok;
        logic [15:0] w [6];
        start_q.delete();
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_initial: got %b required 0", overflow); end
        for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
        for (int i = 0; i < 5; i++) push_word_bits(w[i]);
        @(negedge clk);
        data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = w[i];
            if (i == 5) begin
                tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_full_count: got %0d required 4", fifo_count); end
                tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL ovf_full_ready: got %b required 0", data_ready); end
                tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b required 0", overflow); end
            end
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b required 1", overflow); end
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_dropped_count: got %0d required 4", fifo_count); end
        wait_drain(6 * int'(WORD_CYC), ok);
        tests++; if (!ok) begin fails++; $display("FAIL ovf_drain: %0d bits left, required 0", exp_q.size()); end
        tests++; if (start_q.size() != 5) begin fails++; $display("FAIL ovf_frames: got %0d required 5", start_q.size()); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
        tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL ovf_ready_after: got %b required 1", data_ready); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL ovf_count_after: got %0d required 0", fifo_count); end
    endtask

    task automatic test_reset_mid_frame();
        start_q.delete();
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL mid_overflow_held: got %b required 1", overflow); end
        @(negedge clk);
        push_word_bits(16'h3C96);
        data_valid = 1'b1;
        data_in    = 16'h3C96;
        @(posedge clk);
        #1;
        data_in = 16'h1111;
        @(posedge clk);
        #1;
        data_in = 16'h2222;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL mid_queued: got %0d required 2", fifo_count); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b required 1", busy); end
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_tx: got %b required 1", tx); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d required 0", fifo_count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_reset: got %b required 0", busy); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow_clear: got %b required 0", overflow); end
        reset = 1'b1;
        repeat (3 * WORD_CYC) @(posedge clk);
        #1;
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_after_tx: got %b required 1", tx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_after_busy: got %b required 0", busy); end
        tests++; if (start_q.size() != 1) begin fails++; $display("FAIL mid_frames: got %0d required 1", start_q.size()); end
    endtask

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    task automatic test_parity();
        bit ok;
        start_q.delete();
        @(negedge clk);
        push_word_bits(16'h0107);
        data_in    = 16'h0107;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        for (int n = 0; n <= int'(WORD_CYC) + 1; n++) begin
            @(negedge clk);
            if (n == 2 + 9 * int'(CPB)) begin
                tests++; if (tx !== 1'b1) begin fails++; $display("FAIL parity_byte0: got %b required 1", tx); end
            end
            if (n == 2 + int'(FRAME_BITS * CPB) + 9 * int'(CPB)) begin
                tests++; if (tx !== 1'b1) begin fails++; $display("FAIL parity_byte1: got %b required 1", tx); end
            end
            if (n == int'(WORD_CYC)) begin
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL parity_busy_last: got %b required 1", busy); end
            end
            if (n == int'(WORD_CYC) + 1) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL parity_busy_done: got %b required 0", busy); end
            end
        end
        wait_drain(10, ok);
        tests++; if (!ok) begin fails++; $display("FAIL parity_drain: %0d bits left, required 0", exp_q.size()); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset      = 1'b0;
        data_valid = 1'b0;
        data_in    = 16'h0000;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef OUTPUT_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
